collect_seq: RTL and testbench
==============================

COLLECT_SEQ -- requirements
Module: collect_seq

Interface
REQ-001 Parameter LEN_W, default 16, width of window-length and gap counters.
REQ-002 Parameter RND_W, default 8, width of round counter.
REQ-003 Single clock; reset synchronous, active-high.
REQ-004 clk350  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a capture run; honoured only in IDLE.
REQ-007 abort  input  1  terminate run immediately.
REQ-008 cfg_len  input  LEN_W  Collect cycles per window; 0 treated as 1.
REQ-009 cfg_gap  input  LEN_W  idle cycles between windows.
REQ-010 cfg_rounds  input  RND_W  windows per run; 0 = continuous until abort.
REQ-011 buf_full  input  1  capture buffer full.
REQ-012 rd_ack  input  1  readout of current window complete.
REQ-013 collect  output  1  enables datapath sample capture (Collect).
REQ-014 rd_req  output  1  window ready for readout.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at normal run completion.
REQ-017 ovf  output  1  sticky overflow flag.
REQ-018 round_cnt  output  RND_W  completed windows in current run.
REQ-019 sample_cnt  output  LEN_W  Collect cycles in current window.

Function
REQ-020 States: IDLE, COLLECT, DRAIN, GAP, DONE; all outputs registered.
REQ-021 IDLE: start=1 latches cfg_len, cfg_gap, cfg_rounds, clears ovf, round_cnt, sample_cnt, enters COLLECT next cycle.
REQ-022 start ignored outside IDLE; cfg_* changes after acceptance have no effect until next run.
REQ-023 Latency: start sampled at edge N -> collect high for cycles N+1 .. N+len, exactly len cycles.
REQ-024 sample_cnt increments once per cycle collect=1, cleared on entry to COLLECT.
REQ-025 buf_full=1 in COLLECT: ovf set, collect deasserted next cycle, transition to DRAIN (early end); sample_cnt holds captured count.
REQ-026 COLLECT -> DRAIN after len-th cycle; rd_req=1 throughout DRAIN.
REQ-027 DRAIN: rd_ack=1 -> rd_req low next cycle, round_cnt+1; rd_ack outside DRAIN ignored.
REQ-028 After ack: if cfg_rounds!=0 and round_cnt+1==cfg_rounds -> DONE; else GAP.
REQ-029 GAP: collect low for exactly cfg_gap cycles then COLLECT; cfg_gap=0 -> DRAIN ack goes straight to COLLECT next cycle.
REQ-030 Continuous mode: round_cnt wraps 2^RND_W-1 -> 0, run continues.
REQ-031 DONE: done=1 for one cycle, then IDLE; busy low in IDLE.
REQ-032 abort=1 in any non-IDLE state: IDLE next cycle, collect and rd_req low, done not pulsed, ovf and counters retained.
REQ-033 abort and start same cycle in IDLE: abort wins, run not started.
REQ-034 abort and rd_ack same cycle: abort wins, round_cnt not incremented.

Reset
REQ-035 rst=1: state IDLE; collect, rd_req, busy, done, ovf = 0; round_cnt, sample_cnt = 0; latched cfg = 0.
REQ-036 rst mid-run takes effect at next edge, overrides abort, start and all inputs.

Verification
REQ-037 len=4, gap=2, rounds=2, rd_ack 3 cycles after rd_req -> collect 4 cycles, gap 2, collect 4, done pulse once, round_cnt=2, ovf=0.
REQ-038 len=8, buf_full at 3rd collect cycle -> collect ends after cycle 3, ovf=1, sample_cnt=3, rd_req asserted.
REQ-039 rounds=0, len=1, gap=0, rd_ack immediate, 260 windows -> round_cnt=4, done never asserted, no gap cycles.
REQ-040 abort during DRAIN with rd_ack same cycle -> IDLE, rd_req=0, round_cnt unchanged, no done.
REQ-041 start pulses during busy run and cfg_len changed mid-run -> ignored, windows keep latched length.
REQ-042 rst asserted in COLLECT -> next cycle all outputs at reset values; start one cycle after release accepted normally.

Source files
------------

// File: rtl/collect_seq.sv
// Windowed capture sequencer: opens collect windows of a latched length, hands each
// window to readout, waits a gap, and repeats for a fixed or unlimited number of rounds.
module collect_seq #(
    parameter int LEN_W = 16,
    parameter int RND_W = 8
) (
    input  logic             clk350,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [LEN_W-1:0] cfg_gap,
    input  logic [RND_W-1:0] cfg_rounds,
    input  logic             buf_full,
    input  logic             rd_ack,
    output logic             collect,
    output logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [RND_W-1:0] round_cnt,
    output logic [LEN_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] gap_q;
    logic [RND_W-1:0] rounds_q;
    logic [LEN_W-1:0] gap_cnt_q;
    logic [LEN_W-1:0] sample_cnt_q;
    logic [RND_W-1:0] round_cnt_q;
    logic             collect_q;
    logic             rd_req_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic [LEN_W-1:0] sample_inc_d;
    logic [RND_W-1:0] round_inc_d;
    logic             last_round_d;

    always_comb begin
        sample_inc_d = sample_cnt_q + LEN_W'(1);
        round_inc_d  = round_cnt_q + RND_W'(1);
        // rounds_q == 0 means run until aborted; round_cnt simply wraps
        last_round_d = (rounds_q != '0) && (round_inc_d == rounds_q);
    end

    always_ff @(posedge clk350) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            gap_q        <= '0;
            rounds_q     <= '0;
            gap_cnt_q    <= '0;
            sample_cnt_q <= '0;
            round_cnt_q  <= '0;
            collect_q    <= 1'b0;
            rd_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                // Counters and ovf are kept so software can inspect an aborted run
                state_q   <= S_IDLE;
                collect_q <= 1'b0;
                rd_req_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            len_q        <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                            gap_q        <= cfg_gap;
                            rounds_q     <= cfg_rounds;
                            ovf_q        <= 1'b0;
                            round_cnt_q  <= '0;
                            sample_cnt_q <= '0;
                            collect_q    <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        // The cycle in which buf_full is seen still counts as captured
                        sample_cnt_q <= sample_inc_d;
                        if (buf_full) begin
                            ovf_q <= 1'b1;
                        end
                        if (buf_full || (sample_inc_d == len_q)) begin
                            collect_q <= 1'b0;
                            rd_req_q  <= 1'b1;
                            state_q   <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (rd_ack) begin
                            rd_req_q    <= 1'b0;
                            round_cnt_q <= round_inc_d;
                            if (last_round_d) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else if (gap_q == '0) begin
                                sample_cnt_q <= '0;
                                collect_q    <= 1'b1;
                                state_q      <= S_COLLECT;
                            end else begin
                                gap_cnt_q <= gap_q;
                                state_q   <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == LEN_W'(1)) begin
                            sample_cnt_q <= '0;
                            collect_q    <= 1'b1;
                            state_q      <= S_COLLECT;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - LEN_W'(1);
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        collect_q <= 1'b0;
                        rd_req_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign collect    = collect_q;
    assign rd_req     = rd_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;
    assign round_cnt  = round_cnt_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_collect_seq.sv
// Directed bench for collect_seq: scripted runs with hand-derived cycle counts and
// output values, checked one transaction per line.
module tb_collect_seq;

    localparam int LEN_W = 16;
    localparam int RND_W = 8;

    logic             clk350 = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] cfg_len;
    logic [LEN_W-1:0] cfg_gap;
    logic [RND_W-1:0] cfg_rounds;
    logic             buf_full;
    logic             rd_ack;
    logic             collect;
    logic             rd_req;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [RND_W-1:0] round_cnt;
    logic [LEN_W-1:0] sample_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int n_col, n_gap, n_rdq, n_done, run_len, first_col;
    bit seen_idle;

    collect_seq #(.LEN_W(LEN_W), .RND_W(RND_W)) dut (
        .clk350     (clk350),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_len    (cfg_len),
        .cfg_gap    (cfg_gap),
        .cfg_rounds (cfg_rounds),
        .buf_full   (buf_full),
        .rd_ack     (rd_ack),
        .collect    (collect),
        .rd_req     (rd_req),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .round_cnt  (round_cnt),
        .sample_cnt (sample_cnt)
    );

    always #5 clk350 = ~clk350;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk350);
        #1;
    endtask

    task automatic set_cfg(input int len, input int gap, input int rounds);
        cfg_len    = LEN_W'(len);
        cfg_gap    = LEN_W'(gap);
        cfg_rounds = RND_W'(rounds);
    endtask

    // Starts a run and watches it cycle by cycle; k=1 is the first cycle after the start edge.
    task automatic run_mon(input int ack_delay, input int max_cyc, input bit stop_on_idle,
                           input bit noise);
        int age;
        n_col = 0; n_gap = 0; n_rdq = 0; n_done = 0; run_len = 0; first_col = 0;
        seen_idle = 1'b0;
        age = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (stop_on_idle && !busy) begin
                seen_idle = 1'b1;
                run_len = k;
                break;
            end
            if (collect) begin
                n_col++;
                if (first_col == 0) first_col = k;
            end
            if (rd_req) n_rdq++;
            if (done) n_done++;
            if (busy && !collect && !rd_req && !done) n_gap++;
            if (rd_req) begin
                rd_ack = (age == ack_delay);
                age++;
            end else begin
                rd_ack = 1'b0;
                age = 0;
            end
            if (noise) begin
                start = k[0];
                set_cfg(10, 7, 5);
            end
            step();
        end
        start  = 1'b0;
        rd_ack = 1'b0;
        if (stop_on_idle) check_val("run_finished", 32'(seen_idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; buf_full = 1'b0; rd_ack = 1'b0;
        set_cfg(0, 0, 0);
        repeat (3) step();
        check_val("rst_collect", 32'(collect), 0);
        check_val("rst_rd_req", 32'(rd_req), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_ovf", 32'(ovf), 0);
        check_val("rst_round_cnt", 32'(round_cnt), 0);
        check_val("rst_sample_cnt", 32'(sample_cnt), 0);
        rst = 1'b0;
        step();

        // len=4 gap=2 rounds=2, ack 3 cycles after rd_req
        set_cfg(4, 2, 2);
        run_mon(3, 60, 1'b1, 1'b0);
        check_val("r2_first_collect", first_col, 1);
        check_val("r2_collect_cycles", n_col, 8);
        check_val("r2_gap_cycles", n_gap, 2);
        check_val("r2_rdreq_cycles", n_rdq, 8);
        check_val("r2_done_pulses", n_done, 1);
        check_val("r2_run_len", run_len, 20);
        check_val("r2_round_cnt", 32'(round_cnt), 2);
        check_val("r2_ovf", 32'(ovf), 0);

        // len=0 behaves as len=1
        set_cfg(0, 0, 1);
        run_mon(0, 20, 1'b1, 1'b0);
        check_val("len0_collect_cycles", n_col, 1);
        check_val("len0_run_len", run_len, 4);
        check_val("len0_sample_cnt", 32'(sample_cnt), 1);

        // buf_full on the 3rd collect cycle of an 8-cycle window
        set_cfg(8, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("bf_k1_collect", 32'(collect), 1);
        check_val("bf_k1_sample_cnt", 32'(sample_cnt), 0);
        step();
        step();
        buf_full = 1'b1;
        step();
        buf_full = 1'b0;
        check_val("bf_collect_off", 32'(collect), 0);
        check_val("bf_rd_req", 32'(rd_req), 1);
        check_val("bf_ovf", 32'(ovf), 1);
        check_val("bf_sample_cnt", 32'(sample_cnt), 3);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check_val("bf_done", 32'(done), 1);
        check_val("bf_round_cnt", 32'(round_cnt), 1);
        step();
        check_val("bf_idle_busy", 32'(busy), 0);
        check_val("bf_ovf_sticky", 32'(ovf), 1);

        // start pulses and cfg changes mid-run are ignored
        set_cfg(3, 1, 2);
        run_mon(1, 60, 1'b1, 1'b1);
        check_val("noise_collect_cycles", n_col, 6);
        check_val("noise_gap_cycles", n_gap, 1);
        check_val("noise_done_pulses", n_done, 1);
        check_val("noise_run_len", run_len, 13);
        check_val("noise_round_cnt", 32'(round_cnt), 2);
        check_val("noise_ovf_cleared", 32'(ovf), 0);
        check_val("noise_still_idle", 32'(busy), 0);

        // abort together with rd_ack in DRAIN
        set_cfg(2, 0, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("ab_rd_req", 32'(rd_req), 1);
        rd_ack = 1'b1;
        abort  = 1'b1;
        step();
        rd_ack = 1'b0;
        abort  = 1'b0;
        check_val("ab_busy", 32'(busy), 0);
        check_val("ab_rd_req_off", 32'(rd_req), 0);
        check_val("ab_round_cnt", 32'(round_cnt), 0);
        check_val("ab_sample_kept", 32'(sample_cnt), 2);
        step();
        check_val("ab_no_done", 32'(done), 0);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_val("ab_start_busy", 32'(busy), 0);
        check_val("ab_start_collect", 32'(collect), 0);

        // continuous mode, 260 windows of len 1 with immediate ack
        set_cfg(1, 0, 0);
        run_mon(0, 520, 1'b0, 1'b0);
        check_val("cont_collect_cycles", n_col, 260);
        check_val("cont_gap_cycles", n_gap, 0);
        check_val("cont_done_pulses", n_done, 0);
        check_val("cont_round_wrap", 32'(round_cnt), 4);
        check_val("cont_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("cont_abort_busy", 32'(busy), 0);
        check_val("cont_abort_round", 32'(round_cnt), 4);

        // rst in COLLECT, then a fresh start right after release
        set_cfg(5, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_val("mr_collect", 32'(collect), 1);
        rst = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("mr_collect_off", 32'(collect), 0);
        check_val("mr_busy", 32'(busy), 0);
        check_val("mr_sample_cnt", 32'(sample_cnt), 0);
        check_val("mr_round_cnt", 32'(round_cnt), 0);
        check_val("mr_rd_req", 32'(rd_req), 0);
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("mr_restart_collect", 32'(collect), 1);
        check_val("mr_restart_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("mr_final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
